// File: rtl/imem_program_loader.sv
// imem_program_loader: streams a program image into instruction memory, then releases the core.
// Latency: each accepted word is written in the same cycle; cpu_enable rises on the edge of the last handshake (or after read-back).
// Backpressure: s_ready is high only in LOAD; words beyond num_words are never accepted.
//
// Ports:
//   clk, arst            - clock and asynchronous active-high reset
//   start, num_words     - begin a load of num_words words (sampled in IDLE only)
//   halt                 - leave RUN, return to IDLE
//   s_valid/s_ready/s_data - instruction word stream
//   addr_ext, wen_ext, ren_ext, wdata_ext, rdata_ext - instruction memory external port
//   cpu_enable, busy, done, error, checksum - core enable and status
//
// Optional macro IMEM_LOADER_VERIFY_EN adds a VERIFY state that reads the image back
// and compares its sum against the load checksum before enabling the core.
module imem_program_loader #(
   parameter int unsigned IMEM_WORDS = 512,
   parameter logic [63:0] BASE_ADDR  = 64'd0
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        start,
   input  logic [9:0]  num_words,
   input  logic        halt,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   input  logic [31:0] rdata_ext,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] checksum
);

   localparam logic [10:0] MAX_WORDS = 11'(IMEM_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
`ifdef IMEM_LOADER_VERIFY_EN
      ST_VERIFY = 2'd2,
`endif
      ST_RUN    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [9:0]  num_q, num_d;
   logic        error_q, error_d;
   logic [31:0] checksum_q, checksum_d;
   logic        cpu_enable_q, cpu_enable_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;

   logic        s_ready_c;
   logic        wen_c;
   logic [63:0] addr_c;
   logic [31:0] wdata_c;

`ifdef IMEM_LOADER_VERIFY_EN
   // Read-back pass: vcnt walks 0..num; reads issue for vcnt<num, data for
   // read k arrives at vcnt==k+1 because the memory has one cycle of latency.
   logic [9:0]  vcnt_q, vcnt_d;
   logic [31:0] vsum_q, vsum_d;
   logic        ren_c;
   logic [31:0] vsum_final;
   assign vsum_final = vsum_q + rdata_ext;
`else
   logic unused_rdata;
   assign unused_rdata = ^rdata_ext;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      num_d      = num_q;
      error_d    = error_q;
      checksum_d = checksum_q;
      s_ready_c  = 1'b0;
      wen_c      = 1'b0;
      addr_c     = 64'd0;
      wdata_c    = 32'd0;
`ifdef IMEM_LOADER_VERIFY_EN
      vcnt_d     = vcnt_q;
      vsum_d     = vsum_q;
      ren_c      = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((num_words == 10'd0) || ({1'b0, num_words} > MAX_WORDS)) begin
                  // Illegal length: flag it, stay idle, leave memory untouched.
                  error_d = 1'b1;
               end else begin
                  num_d      = num_words;
                  cnt_d      = 10'd0;
                  checksum_d = 32'd0;
                  error_d    = 1'b0;
                  state_d    = ST_LOAD;
               end
            end
         end

         ST_LOAD: begin
            s_ready_c = 1'b1;
            addr_c    = BASE_ADDR + {52'd0, cnt_q, 2'b00};
            if (s_valid) begin
               wen_c      = 1'b1;
               wdata_c    = s_data;
               cnt_d      = cnt_q + 10'd1;
               checksum_d = checksum_q + s_data;
               if (cnt_q == num_q - 10'd1) begin
`ifdef IMEM_LOADER_VERIFY_EN
                  vcnt_d  = 10'd0;
                  vsum_d  = 32'd0;
                  state_d = ST_VERIFY;
`else
                  state_d = ST_RUN;
`endif
               end
            end
         end

`ifdef IMEM_LOADER_VERIFY_EN
         ST_VERIFY: begin
            if (vcnt_q < num_q) begin
               ren_c  = 1'b1;
               addr_c = BASE_ADDR + {52'd0, vcnt_q, 2'b00};
            end
            if (vcnt_q != 10'd0) begin
               vsum_d = vsum_final;
            end
            vcnt_d = vcnt_q + 10'd1;
            if (vcnt_q == num_q) begin
               // Last read data is in flight this cycle; compare including it.
               if (vsum_final == checksum_q) begin
                  state_d = ST_RUN;
               end else begin
                  error_d = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
`endif

         ST_RUN: begin
            if (halt) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the next state so they line up
      // with the state register itself.
      cpu_enable_d = (state_d == ST_RUN);
      done_d       = (state_d == ST_RUN);
`ifdef IMEM_LOADER_VERIFY_EN
      busy_d       = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
`else
      busy_d       = (state_d == ST_LOAD);
`endif
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 10'd0;
         num_q        <= 10'd0;
         error_q      <= 1'b0;
         checksum_q   <= 32'd0;
         cpu_enable_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
         vcnt_q       <= 10'd0;
         vsum_q       <= 32'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         num_q        <= num_d;
         error_q      <= error_d;
         checksum_q   <= checksum_d;
         cpu_enable_q <= cpu_enable_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
`ifdef IMEM_LOADER_VERIFY_EN
         vcnt_q       <= vcnt_d;
         vsum_q       <= vsum_d;
`endif
      end
   end

   assign s_ready    = s_ready_c;
   assign wen_ext    = wen_c;
   assign addr_ext   = addr_c;
   assign wdata_ext  = wdata_c;
`ifdef IMEM_LOADER_VERIFY_EN
   assign ren_ext    = ren_c;
`else
   assign ren_ext    = 1'b0;
`endif
   assign cpu_enable = cpu_enable_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign checksum   = checksum_q;

endmodule
